// File: rtl/mmul_pkg.sv
// mmul_pkg: default widths, FSM states and index type shared by the
// streaming matrix multiplier and its MAC.
package mmul_pkg;

  localparam int DEF_DW = 16;
  localparam int DEF_N  = 4;
  localparam int DEF_NN = DEF_N * DEF_N;
  localparam int ACCW   = 2 * DEF_DW + $clog2(DEF_N);
  localparam int IDXW   = $clog2(DEF_NN);

  typedef logic [IDXW-1:0] idx_t;

  typedef enum logic [1:0] {
    LOAD_A,
    LOAD_B,
    COMPUTE,
    DRAIN
  } state_t;

endpackage

// File: rtl/mmul_mac.sv
// mmul_mac: one multiply-accumulate per enabled cycle, registered sum.
// MATRIX_MUL_STREAM_SAT_EN makes the output saturate instead of wrap.
module mmul_mac
  import mmul_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int AW = ACCW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_en,
  input  logic          i_clear,
  input  logic [DW-1:0] i_a,
  input  logic [DW-1:0] i_b,
  output logic [DW-1:0] o_acc
);

  localparam int PW = 2 * DW;

  logic [AW-1:0] r_acc;
  logic [PW-1:0] w_prod;

  assign w_prod = PW'(i_a) * PW'(i_b);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= (i_clear ? '0 : r_acc) + AW'(w_prod);
    end
  end

`ifdef MATRIX_MUL_STREAM_SAT_EN
  assign o_acc = (|r_acc[AW-1:DW]) ? '1 : r_acc[DW-1:0];
`else
  logic w_unused_hi;
  assign w_unused_hi = ^r_acc[AW-1:DW];
  assign o_acc       = r_acc[DW-1:0];
`endif

endmodule

// File: rtl/matrix_mul_stream.sv
// matrix_mul_stream: loads A then B over valid/ready, runs N^3 MACs,
// drains C row-major. Optional macro: MATRIX_MUL_STREAM_SAT_EN.
module matrix_mul_stream
  import mmul_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int N  = DEF_N
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  output logic          busy
);

  localparam int NN = N * N;
  localparam int IW = $clog2(NN);
  localparam int KW = $clog2(N);
  localparam int AW = 2 * DW + KW;
  localparam logic [IW-1:0] LASTI = IW'(NN - 1);
  localparam logic [KW-1:0] LASTK = KW'(N - 1);

  state_t r_state;
  state_t w_nstate;

  logic          r_in_rdy;
  logic [IW-1:0] r_idx;
  logic [IW-1:0] r_oidx;
  logic [IW-1:0] r_widx;
  logic          r_wpend;
  logic [KW-1:0] r_i;
  logic [KW-1:0] r_j;
  logic [KW-1:0] r_k;

  logic [DW-1:0] r_a [NN];
  logic [DW-1:0] r_b [NN];
  logic [DW-1:0] r_c [NN];

  logic          w_in_xfer;
  logic          w_out_xfer;
  logic          w_load_done;
  logic          w_mac_en;
  logic          w_k_last;
  logic          w_j_last;
  logic          w_mac_done;
  logic [IW-1:0] w_aidx;
  logic [IW-1:0] w_bidx;
  logic [IW-1:0] w_cidx;
  logic [DW-1:0] w_c;

  assign w_in_xfer   = in_valid && r_in_rdy;
  assign w_out_xfer  = out_valid && out_ready;
  assign w_load_done = w_in_xfer && (r_idx == LASTI);
  assign w_mac_en    = (r_state == COMPUTE);
  assign w_k_last    = (r_k == LASTK);
  assign w_j_last    = (r_j == LASTK);
  assign w_mac_done  = w_mac_en && w_k_last
                    && w_j_last && (r_i == LASTK);

  assign w_aidx = IW'(r_i) * IW'(N) + IW'(r_k);
  assign w_bidx = IW'(r_k) * IW'(N) + IW'(r_j);
  assign w_cidx = IW'(r_i) * IW'(N) + IW'(r_j);

  mmul_mac #(
    .DW (DW),
    .AW (AW)
  ) u_mac (
    .clk     (clk),
    .rst     (rst),
    .i_en    (w_mac_en),
    .i_clear (r_k == '0),
    .i_a     (r_a[w_aidx]),
    .i_b     (r_b[w_bidx]),
    .o_acc   (w_c)
  );

  // in_ready is registered so it stays low for one cycle after reset
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= LOAD_A;
      r_in_rdy <= 1'b0;
    end else begin
      r_state  <= w_nstate;
      r_in_rdy <= (w_nstate == LOAD_A) || (w_nstate == LOAD_B);
    end
  end

  always_comb begin
    w_nstate = r_state;
    unique case (r_state)
      LOAD_A:  if (w_load_done) w_nstate = LOAD_B;
      LOAD_B:  if (w_load_done) w_nstate = COMPUTE;
      COMPUTE: if (w_mac_done) w_nstate = DRAIN;
      DRAIN:   if (w_out_xfer && out_last) w_nstate = LOAD_A;
      default: w_nstate = LOAD_A;
    endcase
  end

  always_comb begin
    in_ready  = r_in_rdy;
    out_valid = 1'b0;
    out_data  = '0;
    out_last  = 1'b0;
    busy      = 1'b0;
    unique case (r_state)
      COMPUTE: busy = 1'b1;
      DRAIN: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_data  = r_c[r_oidx];
        out_last  = (r_oidx == LASTI);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx   <= '0;
      r_oidx  <= '0;
      r_widx  <= '0;
      r_wpend <= 1'b0;
      r_i     <= '0;
      r_j     <= '0;
      r_k     <= '0;
    end else begin
      if (w_in_xfer) begin
        r_idx <= (r_idx == LASTI) ? '0 : r_idx + 1'b1;
      end
      if (w_mac_en) begin
        r_k <= w_k_last ? '0 : r_k + 1'b1;
        if (w_k_last) begin
          r_j <= w_j_last ? '0 : r_j + 1'b1;
          if (w_j_last) begin
            r_i <= (r_i == LASTK) ? '0 : r_i + 1'b1;
          end
        end
      end
      // final sum lands in the MAC register; store it one cycle later
      r_wpend <= w_mac_en && w_k_last;
      if (w_mac_en && w_k_last) begin
        r_widx <= w_cidx;
      end
      if (w_out_xfer) begin
        r_oidx <= out_last ? '0 : r_oidx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_in_xfer && (r_state == LOAD_A)) begin
      r_a[r_idx] <= in_data;
    end
    if (w_in_xfer && (r_state == LOAD_B)) begin
      r_b[r_idx] <= in_data;
    end
    if (r_wpend) begin
      r_c[r_widx] <= w_c;
    end
  end

endmodule

// File: tb/tb_matrix_mul_stream.sv
// tb_matrix_mul_stream: scoreboard bench for the streaming 4x4 multiplier.
// Builds with or without MATRIX_MUL_STREAM_SAT_EN.
module tb_matrix_mul_stream;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_last;
  logic        busy;

  always #5 clk = ~clk;

  matrix_mul_stream dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy)
  );

  typedef struct packed {
    logic [15:0] d;
    logic        l;
  } exp_t;

  exp_t        sb_q[$];
  logic [15:0] ma  [16];
  logic [15:0] mb  [16];
  logic [15:0] cap [16];
  logic [15:0] bid [16] = '{5, 10, 15, 20, 6, 11, 16, 21,
                            7, 12, 17, 22, 8, 13, 18, 23};
`ifdef MATRIX_MUL_STREAM_SAT_EN
  localparam logic [15:0] OVF = 16'hFFFF;
`else
  localparam logic [15:0] OVF = 16'hFFFC;
`endif

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id();
    for (int k = 0; k < 16; k++) begin
      ma[k] = (k % 5 == 0) ? 16'd1 : 16'd0;
    end
    mb = bid;
  endtask

  task automatic set_rand();
    for (int k = 0; k < 16; k++) begin
      ma[k] = 16'($urandom);
      mb[k] = 16'($urandom);
    end
  endtask

  task automatic push_exp();
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        longint s;
        exp_t   e;
        s = 0;
        for (int k = 0; k < 4; k++) begin
          s += longint'(ma[i*4+k]) * longint'(mb[k*4+j]);
        end
`ifdef MATRIX_MUL_STREAM_SAT_EN
        e.d = (s > 64'hFFFF) ? 16'hFFFF : s[15:0];
`else
        e.d = s[15:0];
`endif
        e.l = (i == 3) && (j == 3);
        sb_q.push_back(e);
      end
    end
  endtask

  task automatic load(input bit gaps);
    int guard;
    bit done;
    guard = 0;
    for (int e = 0; e < 32; e++) begin
      done = 1'b0;
      while (!done && guard < 1000) begin
        in_valid = gaps ? 1'($urandom % 2) : 1'b1;
        in_data  = (e < 16) ? ma[e] : mb[e-16];
        done     = in_valid && in_ready;
        tick();
        guard++;
      end
    end
    in_valid = 1'b0;
    chk("load_timeout", 32'(guard < 1000), 1);
  endtask

  task automatic wait_out(input bit hold);
    int n;
    n        = 0;
    in_valid = hold;
    in_data  = 16'hDEAD;
    chk("cmp_ready", in_ready, 0);
    chk("cmp_busy", busy, 1);
    while (!out_valid && n < 200) begin
      tick();
      n++;
    end
    in_valid = 1'b0;
    chk("latency", n, 64);
    chk("drain_busy", busy, 1);
  endtask

  task automatic drain(input bit stall);
    int cyc;
    int oi;
    cyc = 0;
    oi  = 0;
    while (sb_q.size() > 0 && cyc < 500) begin
      out_ready = stall ? (cyc % 4 == 3) : 1'b1;
      if (out_valid) begin
        chk("data", out_data, sb_q[0].d);
        chk("last", out_last, sb_q[0].l);
        if (out_ready) begin
          cap[oi] = out_data;
          oi++;
          void'(sb_q.pop_front());
        end
      end else begin
        chk("valid", out_valid, 1);
      end
      tick();
      cyc++;
    end
    out_ready = 1'b0;
    chk("drain_timeout", sb_q.size(), 0);
    chk("idle_valid", out_valid, 0);
    chk("idle_ready", in_ready, 1);
    chk("idle_busy", busy, 0);
  endtask

  task automatic run(input bit gaps, input bit stall, input bit hold);
    load(gaps);
    push_exp();
    wait_out(hold);
    drain(stall);
  endtask

  task automatic chk_rst_vals(input string tag);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_out_last"}, out_last, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (2) tick();
    chk_rst_vals("rst");
    rst = 1'b0;
    chk("rst_hold_rdy", in_ready, 0);
    tick();
    chk("rst_rdy_up", in_ready, 1);

    set_id();
    run(0, 0, 0);

    for (int k = 0; k < 16; k++) begin
      ma[k] = 16'(k + 1);
      mb[k] = 16'(k + 1);
    end
    run(0, 0, 0);
    chk("gen_c0", cap[0], 90);
    chk("gen_c1", cap[1], 100);
    chk("gen_c2", cap[2], 110);
    chk("gen_c3", cap[3], 120);
    chk("gen_c15", cap[15], 600);

    for (int k = 0; k < 16; k++) begin
      ma[k] = 16'hFFFF;
      mb[k] = 16'd1;
    end
    run(0, 0, 0);
    chk("ovf_c0", cap[0], OVF);
    chk("ovf_c15", cap[15], OVF);

    set_id();
    run(1, 1, 1);
    chk("bp_c15", cap[15], 23);

    set_id();
    load(0);
    repeat (30) tick();
    chk("mid_busy", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_rst_vals("mid");
    tick();
    chk("mid_rdy_up", in_ready, 1);

    set_id();
    run(0, 0, 0);

    set_rand();
    run(0, 0, 0);
    set_rand();
    run(0, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
